// File: rtl/apb_cmd_master.sv
`timescale 1ns/1ps
// apb_cmd_master
// Queued APB3/APB4 master. Register commands enter a small FIFO, are executed
// one at a time as SETUP/ACCESS transfers (honouring pready/pslverr wait
// states), and their results are returned in order through a response FIFO.
//
// Optional feature macro: APB_CMD_MASTER_TIMEOUT_EN
//   When defined, an ACCESS-phase watchdog aborts a transfer after
//   TIMEOUT_CYC cycles without pready and returns an err+tout response.
//   When undefined, ACCESS waits for pready indefinitely and rsp_tout_o is 0.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o       command handshake (ready = FIFO not full)
//   cmd_write_i/addr/wdata/strb   command fields
//   rsp_valid_o/rsp_ready_i       response handshake (first-word fall-through)
//   rsp_write_o/rdata/err/tout    response fields
//   paddr_o..penable_o            APB request side
//   pready_i/pslverr_i/prdata_i   APB completion side
//   busy_o                        transfer active or commands queued
//   err_cnt_o                     saturating count of error responses
module apb_cmd_master #(
  parameter int BUS_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]    cmd_wdata_i,
  input  logic [BUS_WIDTH/8-1:0]  cmd_strb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic                    rsp_write_o,
  output logic [BUS_WIDTH-1:0]    rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_tout_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic                    pwrite_o,
  output logic [BUS_WIDTH-1:0]    pwdata_o,
  output logic [BUS_WIDTH/8-1:0]  pstrb_o,
  output logic                    psel_o,
  output logic                    penable_o,
  input  logic                    pready_i,
  input  logic                    pslverr_i,
  input  logic [BUS_WIDTH-1:0]    prdata_i,
  output logic                    busy_o,
  output logic [7:0]              err_cnt_o
);

  localparam int STRB_W = BUS_WIDTH / 8;
  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CMD_W  = 1 + ADDR_WIDTH + BUS_WIDTH + STRB_W;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int RSP_W  = BUS_WIDTH + 3;   // {write, rdata, err, tout}
`else
  localparam int RSP_W  = BUS_WIDTH + 2;   // {write, rdata, err}
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  state_t state_reg;

  // ---------------- command FIFO ----------------
  logic [CMD_W-1:0] cmd_mem [CMD_DEPTH];
  logic [PTR_W-1:0] cmd_wr_ptr_reg;
  logic [PTR_W-1:0] cmd_rd_ptr_reg;
  logic [CNT_W-1:0] cmd_count_reg;
  logic             cmd_push;
  logic             cmd_pop;
  logic             cmd_empty;
  logic [CMD_W-1:0] cmd_head;
  logic             head_write;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [BUS_WIDTH-1:0]  head_wdata;
  logic [STRB_W-1:0]     head_strb;

  assign cmd_ready_o = (cmd_count_reg != CNT_W'(CMD_DEPTH));
  assign cmd_empty   = (cmd_count_reg == '0);
  assign cmd_push    = cmd_valid_i & cmd_ready_o;
  assign cmd_head    = cmd_mem[cmd_rd_ptr_reg];
  assign {head_write, head_addr, head_wdata, head_strb} = cmd_head;

  always_ff @(posedge clk_i) begin
    if (cmd_push) begin
      cmd_mem[cmd_wr_ptr_reg] <= {cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_wr_ptr_reg <= '0;
      cmd_rd_ptr_reg <= '0;
      cmd_count_reg  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr_reg <= cmd_wr_ptr_reg + 1'b1;
      if (cmd_pop)  cmd_rd_ptr_reg <= cmd_rd_ptr_reg + 1'b1;
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_count_reg <= cmd_count_reg + 1'b1;
        2'b01:   cmd_count_reg <= cmd_count_reg - 1'b1;
        default: cmd_count_reg <= cmd_count_reg;
      endcase
    end
  end

  // ---------------- response FIFO ----------------
  logic [RSP_W-1:0] rsp_mem [CMD_DEPTH];
  logic [PTR_W-1:0] rsp_wr_ptr_reg;
  logic [PTR_W-1:0] rsp_rd_ptr_reg;
  logic [CNT_W-1:0] rsp_count_reg;
  logic             rsp_push;
  logic             rsp_pop;
  logic             rsp_full;
  logic             rsp_full_after;
  logic [RSP_W-1:0] rsp_din;
  logic [RSP_W-1:0] rsp_head;
  logic [BUS_WIDTH-1:0] rsp_rdata_in;
  logic             rsp_err_in;
  logic             access_done;
  logic             tout_abort;

  assign rsp_valid_o = (rsp_count_reg != '0);
  assign rsp_full    = (rsp_count_reg == CNT_W'(CMD_DEPTH));
  assign rsp_pop     = rsp_valid_o & rsp_ready_i;
  // A transfer only reaches ACCESS with a slot reserved, so here the count
  // is at most DEPTH-1; after this edge's push the FIFO is full only when
  // it held DEPTH-1 entries and nothing is being popped.
  assign rsp_full_after = ~rsp_pop & (rsp_count_reg == CNT_W'(CMD_DEPTH - 1));

  assign access_done  = (state_reg == ST_ACCESS) & pready_i;
  assign rsp_push     = access_done | tout_abort;
  assign rsp_rdata_in = (pwrite_reg_q() | tout_abort) ? '0 : prdata_i;
  assign rsp_err_in   = tout_abort | pslverr_i;

  assign rsp_head    = rsp_mem[rsp_rd_ptr_reg];
  assign rsp_write_o = rsp_head[RSP_W-1];
  assign rsp_rdata_o = rsp_head[RSP_W-2 -: BUS_WIDTH];
  assign rsp_err_o   = rsp_head[RSP_W-2-BUS_WIDTH];

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  assign rsp_din    = {pwrite_o, rsp_rdata_in, rsp_err_in, tout_abort};
  assign rsp_tout_o = rsp_head[0];
`else
  assign rsp_din    = {pwrite_o, rsp_rdata_in, rsp_err_in};
  assign rsp_tout_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rsp_push) begin
      rsp_mem[rsp_wr_ptr_reg] <= rsp_din;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_wr_ptr_reg <= '0;
      rsp_rd_ptr_reg <= '0;
      rsp_count_reg  <= '0;
    end else begin
      if (rsp_push) rsp_wr_ptr_reg <= rsp_wr_ptr_reg + 1'b1;
      if (rsp_pop)  rsp_rd_ptr_reg <= rsp_rd_ptr_reg + 1'b1;
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_count_reg <= rsp_count_reg + 1'b1;
        2'b01:   rsp_count_reg <= rsp_count_reg - 1'b1;
        default: rsp_count_reg <= rsp_count_reg;
      endcase
    end
  end

  // ---------------- ACCESS watchdog ----------------
`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int TOUT_W = $clog2(TIMEOUT_CYC + 1);
  logic [TOUT_W-1:0] tout_cnt_reg;

  // Abort on the last permitted ACCESS cycle that still sees no pready.
  assign tout_abort = (state_reg == ST_ACCESS) & ~pready_i &
                      (tout_cnt_reg == TOUT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || state_reg == ST_SETUP) begin
      tout_cnt_reg <= '0;
    end else if (state_reg == ST_ACCESS) begin
      tout_cnt_reg <= tout_cnt_reg + 1'b1;
    end
  end
`else
  assign tout_abort = 1'b0;
`endif

  // ---------------- transfer FSM ----------------
  // Pop a command from IDLE when a response slot is free, or chain directly
  // from a completing ACCESS when a slot remains after this edge.
  assign cmd_pop = ~cmd_empty &
                   (((state_reg == ST_IDLE) & ~rsp_full) |
                    (access_done & ~rsp_full_after));

  function automatic logic pwrite_reg_q();
    return pwrite_o;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      paddr_o   <= '0;
      pwrite_o  <= 1'b0;
      pwdata_o  <= '0;
      pstrb_o   <= '0;
    end else begin
      if (cmd_pop) begin
        paddr_o  <= head_addr;
        pwrite_o <= head_write;
        pwdata_o <= head_write ? head_wdata : '0;
        pstrb_o  <= head_write ? head_strb  : '0;
      end
      case (state_reg)
        ST_IDLE: begin
          if (cmd_pop) begin
            state_reg <= ST_SETUP;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
          end
        end
        ST_SETUP: begin
          state_reg <= ST_ACCESS;
          penable_o <= 1'b1;
        end
        ST_ACCESS: begin
          if (access_done && cmd_pop) begin
            state_reg <= ST_SETUP;
            penable_o <= 1'b0;
          end else if (access_done || tout_abort) begin
            state_reg <= ST_IDLE;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- status ----------------
  logic [7:0] err_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_reg <= '0;
    end else if (rsp_push && rsp_err_in && err_cnt_reg != 8'hFF) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_cnt_o = err_cnt_reg;
  assign busy_o    = (state_reg != ST_IDLE) | ~cmd_empty;

endmodule

// File: tb/tb_apb_cmd_master.sv
`timescale 1ns/1ps
// Directed testbench for apb_cmd_master with a small parametrisable APB
// slave (programmable wait states, per-address error, optional never-ready).
module tb_apb_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_tout;
  logic [15:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        psel;
  logic        penable;
  logic        pready;
  logic        pslverr;
  logic [31:0] prdata;
  logic        busy;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  apb_cmd_master #(
    .BUS_WIDTH(32), .ADDR_WIDTH(16), .CMD_DEPTH(4), .TIMEOUT_CYC(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .rsp_tout_o(rsp_tout),
    .paddr_o(paddr), .pwrite_o(pwrite), .pwdata_o(pwdata), .pstrb_o(pstrb),
    .psel_o(psel), .penable_o(penable),
    .pready_i(pready), .pslverr_i(pslverr), .prdata_i(prdata),
    .busy_o(busy), .err_cnt_o(err_cnt)
  );

  // ---------------- slave model ----------------
  int          slv_wait = 0;
  bit          slv_never = 1'b0;
  bit          slv_fixed = 1'b0;
  logic [31:0] slv_data = '0;
  logic [15:0] err_a = 16'hFFFF;
  logic [15:0] err_b = 16'hFFFF;
  int          acc_cnt = 0;

  assign pready  = psel && penable && !slv_never && (acc_cnt >= slv_wait);
  assign pslverr = psel && penable && (paddr == err_a || paddr == err_b);
  assign prdata  = slv_fixed ? slv_data : {16'hC0DE, paddr};

  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
  end

  // SETUP-phase monitor used for throughput measurement
  int cyc = 0;
  bit mon_en = 1'b0;
  int first_setup = -1;
  int last_setup = -1;
  int n_setup = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mon_en && psel && !penable) begin
      if (first_setup < 0) first_setup <= cyc;
      last_setup <= cyc;
      n_setup    <= n_setup + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic w, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    bit done;
    done = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    for (int i = 0; i < 50 && !done; i++) begin
      if (cmd_ready) done = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    check_eq("cmd_accept", done, 1);
  endtask

  task automatic get_rsp(output logic w, output logic [31:0] d, output logic e, output logic t);
    bit got;
    got = 1'b0; w = 1'b0; d = '0; e = 1'b0; t = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      if (rsp_valid) begin
        w = rsp_write; d = rsp_rdata; e = rsp_err; t = rsp_tout;
        got = 1'b1;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
      end else begin
        tick();
      end
    end
    check_eq("rsp_arrive", got, 1);
    $display("rsp: write=%0d rdata=0x%08h err=%0d tout=%0d", w, d, e, t);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        w, e, t;
    logic [31:0] d;
    int          n_acc;
    int          n_sel;
    bit          stable_ok;
    logic [15:0] a;

    repeat (3) tick();
    check_eq("rst_psel", psel, 0);
    check_eq("rst_penable", penable, 0);
    check_eq("rst_paddr", paddr, 0);
    check_eq("rst_pwdata", pwdata, 0);
    check_eq("rst_pstrb_pwrite", {pstrb, pwrite}, 0);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    tick();

    // --- T1: zero-wait write, phase timing ---
    send_cmd(1'b1, 16'h0010, 32'h0000_00A5, 4'hF);   // accepted at edge k
    check_eq("t1_k_psel", psel, 0);
    check_eq("t1_k_busy", busy, 1);
    tick();                                          // after k+1
    check_eq("t1_setup", {psel, penable}, 2'b10);
    check_eq("t1_paddr", paddr, 16'h0010);
    check_eq("t1_pwdata", pwdata, 32'h0000_00A5);
    check_eq("t1_pstrb_pwrite", {pstrb, pwrite}, 5'b11111);
    tick();                                          // after k+2
    check_eq("t1_access", {psel, penable}, 2'b11);
    check_eq("t1_rsp_early", rsp_valid, 0);
    tick();                                          // after k+3
    check_eq("t1_rsp_valid", rsp_valid, 1);
    check_eq("t1_psel_drop", psel, 0);
    check_eq("t1_busy_idle", busy, 0);
    get_rsp(w, d, e, t);
    check_eq("t1_rsp", {w, d, e, t}, {1'b1, 32'h0, 1'b0, 1'b0});
    check_eq("t1_rsp_empty", rsp_valid, 0);

    // --- T2: read with 3 wait states ---
    slv_wait = 3; slv_fixed = 1'b1; slv_data = 32'hDEAD_BEEF;
    send_cmd(1'b0, 16'h0020, 32'h1234_5678, 4'hF);
    n_sel = 0; stable_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid) break;
      if (psel) begin
        n_sel++;
        if (paddr != 16'h0020 || pwdata != 32'h0 || pstrb != 4'h0 || pwrite) stable_ok = 1'b0;
      end
    end
    check_eq("t2_psel_cycles", n_sel, 5);
    check_eq("t2_req_stable", stable_ok, 1);
    get_rsp(w, d, e, t);
    check_eq("t2_rsp", {w, d, e, t}, {1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0});
    slv_wait = 0; slv_fixed = 1'b0;

    // --- T3: back-pressure with both FIFOs filling, then ordered drain ---
    n_acc = 0;
    for (int c = 0; c < 40; c++) begin
      bit acc;
      if (n_acc < 10) begin
        cmd_valid = 1'b1;
        cmd_write = (n_acc % 3 == 0);
        cmd_addr  = 16'(16'h0100 + n_acc * 4);
        cmd_wdata = 32'hA000_0000 + 32'(n_acc);
        cmd_strb  = 4'hF;
      end else begin
        cmd_valid = 1'b0;
      end
      acc = cmd_valid && cmd_ready;
      tick();
      if (acc) n_acc++;
    end
    cmd_valid = 1'b0;
    check_eq("t3_accepted", n_acc, 8);
    check_eq("t3_cmd_full", cmd_ready, 0);
    check_eq("t3_rsp_held", rsp_valid, 1);
    check_eq("t3_apb_stalled", psel, 0);
    check_eq("t3_busy", busy, 1);
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 16'(16'h0100 + i * 4);
      get_rsp(w, d, e, t);
      if (i % 3 == 0) check_eq("t3_rsp_order", {w, d, e}, {1'b1, 32'h0, 1'b0});
      else            check_eq("t3_rsp_order", {w, d, e}, {1'b0, 16'hC0DE, a, 1'b0});
    end
    mon_en = 1'b0;
    tick();
    check_eq("t3_setups", n_setup, 4);
    check_eq("t3_b2b_span", last_setup - first_setup, 6);
    check_eq("t3_drained", {rsp_valid, busy, cmd_ready}, 3'b001);

    // --- T4: slave errors on 2 of 5 reads ---
    err_a = 16'h0044; err_b = 16'h004C;
    for (int i = 0; i < 5; i++) send_cmd(1'b0, 16'(16'h0040 + i * 4), 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      a = 16'(16'h0040 + i * 4);
      get_rsp(w, d, e, t);
      check_eq("t4_rsp", {w, d, e, t}, {1'b0, 16'hC0DE, a, (i == 1 || i == 3), 1'b0});
    end
    check_eq("t4_err_cnt", err_cnt, 2);
    err_a = 16'hFFFF; err_b = 16'hFFFF;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    // --- T5: watchdog abort after 8 ACCESS cycles ---
    slv_never = 1'b1;
    send_cmd(1'b0, 16'h0060, 32'h0, 4'h0);
    n_sel = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rsp_valid) break;
      if (psel && penable) n_sel++;
    end
    check_eq("t5_access_cycles", n_sel, 8);
    check_eq("t5_psel_drop", {psel, penable}, 2'b00);
    get_rsp(w, d, e, t);
    check_eq("t5_rsp", {w, d, e, t}, {1'b0, 32'h0, 1'b1, 1'b1});
    check_eq("t5_err_cnt", err_cnt, 3);
    slv_never = 1'b0;
    send_cmd(1'b0, 16'h0064, 32'h0, 4'h0);
    get_rsp(w, d, e, t);
    check_eq("t5_after", {w, d, e, t}, {1'b0, 32'hC0DE_0064, 1'b0, 1'b0});
`endif

    // --- T6: reset during ACCESS with 2 commands queued ---
    slv_wait = 50;
    send_cmd(1'b0, 16'h0070, 32'h0, 4'h0);
    send_cmd(1'b1, 16'h0074, 32'h1, 4'h1);
    send_cmd(1'b0, 16'h0078, 32'h0, 4'h0);
    check_eq("t6_in_access", {psel, penable, cmd_ready}, 3'b111);
    rst = 1'b1;
    tick();
    check_eq("t6_psel", {psel, penable}, 2'b00);
    check_eq("t6_cmd_ready", cmd_ready, 1);
    check_eq("t6_rsp_valid", rsp_valid, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_err_cnt", err_cnt, 0);
    rst = 1'b0;
    slv_wait = 0;
    repeat (4) tick();
    check_eq("t6_quiet", {psel, rsp_valid, busy}, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
